// File: rtl/rhythm_tick_gen.sv
// Multi-channel tick generator: per-channel programmable divisor producing one-cycle
// enable strobes plus a half-rate square output; divisor changes land only on period boundaries.
module rhythm_tick_gen #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEF_DIV = 25_000,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'((DEF_DIV < 2) ? 2 : DEF_DIV);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

  logic [CNT_W-1:0]  p_q   [NUM_CH];
  logic [CNT_W-1:0]  p_d   [NUM_CH];
  logic [CNT_W-1:0]  n_q   [NUM_CH];
  logic [CNT_W-1:0]  n_d   [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [NUM_CH-1:0] wrap_c, apply_c, wr_hit_c;
  logic [CNT_W-1:0]  wr_val_c;

  always_comb begin
    wr_val_c = (div_val < TWO) ? TWO : div_val;
    wrap_c   = '0;
    apply_c  = '0;
    wr_hit_c = '0;
    pend_d   = pend_q;
    tick_d   = '0;
    sq_d     = sq_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      p_d[i]   = p_q[i];
      n_d[i]   = n_q[i];
      cnt_d[i] = cnt_q[i] + ONE;

      wrap_c[i]   = ch_en[i] && (cnt_q[i] == (p_q[i] - ONE));
      apply_c[i]  = sync_restart || !ch_en[i] || wrap_c[i];
      wr_hit_c[i] = div_wr && (div_ch == CH_W'(i));

      if (sync_restart) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (!ch_en[i]) begin
        cnt_d[i] = '0;
      end else if (wrap_c[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        sq_d[i]   = ~sq_q[i];
      end

      if (apply_c[i] && pend_q[i]) begin
        p_d[i]    = n_q[i];
        pend_d[i] = 1'b0;
      end
      // A write on the applying edge wins over the clear: it waits for the next boundary.
      if (wr_hit_c[i]) begin
        n_d[i]    = wr_val_c;
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        p_q[i]   <= DEF_P;
        n_q[i]   <= DEF_P;
        cnt_q[i] <= '0;
      end
      pend_q <= '0;
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        p_q[i]   <= p_d[i];
        n_q[i]   <= n_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;
  assign pend = pend_q;

endmodule

// File: tb/tb_rhythm_tick_gen.sv
// Bench for rhythm_tick_gen: countdown reference model checked every cycle, directed
// scenarios with hand-computed expectations, then randomized traffic.
module tb_rhythm_tick_gen;

  localparam int unsigned NCH  = 5;
  localparam int unsigned CW   = 16;
  localparam int unsigned DDIV = 10;
  localparam int unsigned CHW  = 3;

  logic            clk_50m = 1'b0;
  logic            rst;
  logic [NCH-1:0]  ch_en;
  logic            sync_restart;
  logic            div_wr;
  logic [CHW-1:0]  div_ch;
  logic [CW-1:0]   div_val;
  logic [NCH-1:0]  tick, sq, pend;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  // Reference model: edges remaining until the next tick, active/pending period, tick parity.
  int unsigned m_p   [NCH];
  int unsigned m_n   [NCH];
  int unsigned m_rem [NCH];
  bit          m_pend[NCH];
  bit          m_tick[NCH];
  bit          m_sq  [NCH];

  rhythm_tick_gen #(
    .NUM_CH (NCH),
    .CNT_W  (CW),
    .DEF_DIV(DDIV)
  ) dut (
    .clk_50m     (clk_50m),
    .rst         (rst),
    .ch_en       (ch_en),
    .sync_restart(sync_restart),
    .div_wr      (div_wr),
    .div_ch      (div_ch),
    .div_val     (div_val),
    .tick        (tick),
    .sq          (sq),
    .pend        (pend)
  );

  always #5 clk_50m = ~clk_50m;

  always @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      cyc = 0;
      for (int i = 0; i < NCH; i++) begin
        m_p[i] = DDIV; m_n[i] = DDIV; m_rem[i] = DDIV;
        m_pend[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < NCH; i++) begin
        bit boundary;
        boundary = 0;
        m_tick[i] = 0;
        if (sync_restart) begin
          boundary = 1;
          m_sq[i] = 0;
        end else if (!ch_en[i]) begin
          boundary = 1;
        end else begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            boundary = 1;
            m_tick[i] = 1;
            m_sq[i] = !m_sq[i];
          end
        end
        if (boundary) begin
          if (m_pend[i]) m_p[i] = m_n[i];
          m_pend[i] = 0;
          m_rem[i] = m_p[i];
        end
        if (div_wr && int'(div_ch) == i) begin
          m_n[i] = (div_val < 2) ? 2 : int'(div_val);
          m_pend[i] = 1;
        end
      end
    end
  end

  always @(negedge clk_50m) begin
    logic [NCH-1:0] e_tick, e_sq, e_pend;
    for (int i = 0; i < NCH; i++) begin
      e_tick[i] = m_tick[i];
      e_sq[i]   = m_sq[i];
      e_pend[i] = m_pend[i];
    end
    checks++;
    if (tick !== e_tick) begin
      failures++;
      $display("FAIL model_tick cyc=%0d got=%b expected=%b", cyc, tick, e_tick);
    end
    checks++;
    if (sq !== e_sq) begin
      failures++;
      $display("FAIL model_sq cyc=%0d got=%b expected=%b", cyc, sq, e_sq);
    end
    checks++;
    if (pend !== e_pend) begin
      failures++;
      $display("FAIL model_pend cyc=%0d got=%b expected=%b", cyc, pend, e_pend);
    end
  end

  task automatic lit(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic wr(input int unsigned ch, input int unsigned val);
    div_wr  = 1'b1;
    div_ch  = CHW'(ch);
    div_val = CW'(val);
  endtask

  initial begin
    rst = 1'b0; ch_en = '1; sync_restart = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk_50m);
    rst = 1'b0;

    // Directed timeline: at iteration c we sit just after edge c; inputs set here are sampled at edge c+1.
    for (int c = 0; c <= 130; c++) begin
      case (c)
        0:   begin lit("rst_tick", tick, 0); lit("rst_sq", sq, 0); lit("rst_pend", pend, 0); end
        10:  begin lit("first_tick", tick, 5'h1F); lit("first_sq", sq, 5'h1F); end
        11:  lit("tick_one_wide", tick, 0);
        20:  begin lit("second_tick", tick, 5'h1F); lit("sq_back", sq, 0); end
        30:  lit("third_tick", tick, 5'h1F);
        34:  lit("ch1_pend_rise", pend, 5'b00010);
        39:  lit("ch1_pend_held", pend[1], 1);
        40:  begin lit("ch1_pend_fall", pend[1], 0); lit("ch1_old_period", tick[1], 1); end
        43:  lit("ch1_no_early", tick[1], 0);
        44:  lit("ch1_new_period", tick[1], 1);
        58:  lit("bad_ch_ignored", pend, 5'b00100);
        60:  begin lit("ch2_wrap", tick[2], 1); lit("ch2_apply", pend[2], 0); end
        65:  lit("ch2_latest", tick[2], 1);
        67:  lit("ch2_not_seven", tick[2], 0);
        70:  begin lit("ch2_again", tick[2], 1); lit("ch0_wrap", tick[0], 1); lit("ch0_pend_kept", pend[0], 1); end
        75:  lit("ch3_pend_dis", pend[3], 1);
        77:  begin lit("ch0_pend_wait", pend[0], 1); lit("ch0_no_tick", tick[0], 0); end
        78:  begin lit("ch0_eight", tick[0], 1); lit("ch0_pend_clear", pend[0], 0); end
        81:  lit("ch0_three", tick[0], 1);
        76:  lit("ch3_pend_fast", pend[3], 0);
        85:  lit("ch3_sq_hold", sq[3], 1);
        100: lit("ch3_no_early", tick[3], 0);
        101: begin lit("ch3_reenable", tick[3], 1); lit("ch3_sq_toggle", sq[3], 0); end
        120: begin lit("restart_tick", tick, 0); lit("restart_sq", sq, 0); lit("restart_pend", pend, 0); end
        122: lit("ch2_min_period", tick[2], 1);
        124: lit("aligned_ticks", tick, 5'b10110);
        default: ;
      endcase

      div_wr = 1'b0;
      sync_restart = 1'b0;
      ch_en = (c >= 70 && c <= 94) ? 5'b10111 : 5'h1F;
      case (c)
        33:  wr(1, 4);
        51:  wr(2, 7);
        54:  wr(2, 5);
        56:  wr(5, 3);
        57:  wr(7, 0);
        60:  wr(0, 8);
        69:  wr(0, 3);
        74:  wr(3, 6);
        89:  wr(4, 4);
        99:  wr(2, 0);
        119: sync_restart = 1'b1;
        128: wr(0, 5);
        default: ;
      endcase
      @(negedge clk_50m);
    end

    // Asynchronous reset mid-period drops everything, including the pending ch0 write.
    div_wr = 1'b0;
    @(posedge clk_50m);
    #2 rst = 1'b1;
    @(negedge clk_50m);
    lit("arst_tick", tick, 0);
    lit("arst_sq", sq, 0);
    lit("arst_pend", pend, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk_50m);
    lit("arst_def_period", tick, 5'h1F);

    for (int k = 0; k < 3000; k++) begin
      logic [NCH-1:0] en;
      for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 7) != 0);
      ch_en        = en;
      div_wr       = ($urandom_range(0, 5) == 0);
      div_ch       = CHW'($urandom_range(0, 7));
      div_val      = CW'($urandom_range(0, 12));
      sync_restart = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      @(negedge clk_50m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
